// File: rtl/framebuffer_scanout_if.sv
// Frame-buffer read port plus video outputs of the scanout engine.
// master: scanout engine (issues reads, drives video); slave: memory/display side.
// Read data is expected one cycle after rd_en; there is no backpressure.
interface framebuffer_scanout_if;
  logic [15:0] rd_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        pixel;

  modport master (
    input  rd_data,
    output rd_en, rd_addr, hsync, vsync, de, pixel
  );

  modport slave (
    output rd_data,
    input  rd_en, rd_addr, hsync, vsync, de, pixel
  );
endinterface

// File: rtl/framebuffer_scanout.sv
// 1bpp frame-buffer scanout: raster timing, word prefetch and pixel serialisation.
// Latency: video outputs are registered, one cycle behind the h/v counters.
// Backpressure: none; the buffer must return rd_data exactly one cycle after rd_en.
module framebuffer_scanout #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 8,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 13,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  framebuffer_scanout_if.master fb
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int WPL   = H_VIS / 16;

  localparam logic [9:0] H_LAST      = 10'(H_TOT - 1);
  localparam logic [9:0] H_PRE       = 10'(H_TOT - 2);
  localparam logic [9:0] H_VIS_END   = 10'(H_VIS);
  localparam logic [9:0] H_SYNC_ST   = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] H_LINE_LAST = 10'(H_VIS - 18);
  localparam logic [9:0] V_LAST      = 10'(V_TOT - 1);
  localparam logic [9:0] V_VIS_END   = 10'(V_VIS);
  localparam logic [9:0] V_PRE_LIM   = 10'(V_VIS - 1);
  localparam logic [9:0] V_SYNC_ST   = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [15:0] PTR_LAST   = 16'(WPL * V_VIS - 1);

  logic [9:0]  h;
  logic [9:0]  v;
  logic [15:0] ptr;
  logic [15:0] last_addr;
  logic [15:0] word_reg;
  logic        primed;
  logic        cap;
  logic        pre_slot;
  logic        line_slot;
  logic        issue;
  logic        vis;
  logic        hs_act;
  logic        vs_act;
  logic        hsync_q;
  logic        vsync_q;
  logic        de_q;
  logic        pixel_q;

  // Raster counters: h wraps every line, v steps on the last h of each line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Read slots and region decode. Until the first end-of-frame prefetch the
  // pointer is not aligned to the raster, so every read except that prefetch
  // is held off and the first frame after reset stays black.
  always_comb begin
    pre_slot  = (h == H_PRE) && ((v == V_LAST) || (v < V_PRE_LIM));
    line_slot = (h[3:0] == 4'd14) && (h <= H_LINE_LAST) && (v < V_VIS_END);
    issue     = (pre_slot && (primed || (v == V_LAST))) || (line_slot && primed);
    vis       = (h < H_VIS_END) && (v < V_VIS_END);
    hs_act    = (h >= H_SYNC_ST) && (h < H_SYNC_END);
    vs_act    = (v >= V_SYNC_ST) && (v < V_SYNC_END);
  end

  // Word pointer walks the buffer linearly and wraps after the last word, so
  // the end-of-frame prefetch always finds it back at word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      last_addr <= '0;
      primed    <= 1'b0;
    end else if (issue) begin
      last_addr <= ptr;
      ptr       <= (ptr == PTR_LAST) ? 16'd0 : ptr + 16'd1;
      if (v == V_LAST) primed <= 1'b1;
    end
  end

  // Capture the returned word one cycle after the strobe; reset drops any
  // capture still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap      <= 1'b0;
      word_reg <= '0;
    end else begin
      cap <= issue;
      if (cap) word_reg <= fb.rd_data;
    end
  end

  // Registered video outputs; LSB of each word is the leftmost pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      pixel_q <= 1'b0;
    end else begin
      hsync_q <= !hs_act;
      vsync_q <= !vs_act;
      de_q    <= vis;
      pixel_q <= vis & word_reg[h[3:0]];
    end
  end

  // Address is presented with the strobe and held at the last read otherwise.
  assign fb.rd_en   = issue;
  assign fb.rd_addr = issue ? ptr : last_addr;
  assign fb.hsync   = hsync_q;
  assign fb.vsync   = vsync_q;
  assign fb.de      = de_q;
  assign fb.pixel   = pixel_q;

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 The block SHALL have exactly one clock and reset, with reset asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk  input  1  system/pixel clock, rising edge.
- reset  input  1  asynchronous, active-low.
- rd_data  input  16  frame-buffer word, valid the cycle after rd_en.
- rd_en  output  1  buffer read strobe.
- rd_addr  output  16  buffer word address, 0..23999.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- de  output  1  display enable, high on visible pixels.
- pixel  output  1  monochrome pixel, 1 = white.

REQ-003 Buffer format SHALL be 1 bit per pixel, 16 pixels per word, 50 words per line, 480 lines.
- Word address = line*50 + (x>>4).
- Bit index = x[3:0], LSB is the leftmost pixel.

Function
REQ-004 A horizontal counter h SHALL count 0..975 and then wrap to 0.
REQ-005 A vertical counter v SHALL increment only on h==975, counting 0..527 and then wrapping to 0.
REQ-006 Timing regions SHALL be (values are counter values):
- Horizontal: visible 0..799, front porch 800..839, sync 840..967, back porch 968..975.
- Vertical: visible 0..479, front porch 480..492, sync 493..495, back porch 496..527.

REQ-007 The outputs hsync, vsync, de and pixel SHALL be registered, so each output shows its counter state exactly 1 cycle later.
- hsync = 0 iff h in 840..967.
- vsync = 0 iff v in 493..495.
- de = 1 iff h<800 and v<480.
- pixel = word_reg[h[3:0]] when de is true, else 0.

REQ-008 Read issue SHALL follow these rules, with rd_en high for exactly 1 cycle per read:
- Line prefetch: read at h==974 when v==527 or v<479, fetching word 0 of the next visible line.
- In-line reads: read at h[3:0]==14 with h<=782 and v<480, fetching word (h>>4)+1 of the current line.

REQ-009 rd_data SHALL be captured into word_reg on the cycle after rd_en, which is h==975 or h[3:0]==15. word_reg then holds the correct word for all 16 pixels of the next group.
REQ-010 rd_addr SHALL be driven from a word pointer.
- The pointer advances by 1 after each read.
- The read issued at h==974, v==527 SHALL use address 0, and the pointer then becomes 1.
- The pointer SHALL never exceed 23999.
- Exactly 24000 reads SHALL occur per frame.

REQ-011 No reads SHALL occur during blanking, apart from the line prefetch in REQ-008.
REQ-012 rd_addr SHALL hold its last value when rd_en is low.
REQ-013 After reset release, the first frame SHALL start at h=0, v=0 with word_reg=0, so line 0 of the first frame displays black.
- Normal display begins with the first prefetch, which occurs at v=527.

Reset
REQ-014 While reset is low, all of the following SHALL hold:
- h = 0, v = 0, word pointer = 0, word_reg = 0.
- rd_en = 0, rd_addr = 0.
- hsync = 1, vsync = 1, de = 0, pixel = 0.

REQ-015 Reset asserted mid-frame SHALL take effect immediately (asynchronously) and abort any pending capture. The rd_data that follows SHALL be ignored.
REQ-016 Timing SHALL restart from h=0, v=0 on the first rising edge after reset is released.

Verification
REQ-017 Timing check: run 2 full frames and measure the outputs.
- Frame period = 976*528 = 515328 cycles.
- hsync low for 128 cycles per line.
- vsync low for 3 lines, i.e. 2928 cycles.
- de high for 800 cycles on each of 480 lines.

REQ-018 Address sequence: use a RAM model that returns rd_data = address.
- Per frame: reads 0..23999 in order, with no duplicates or gaps.
- Prefetch of address 0 at h=974, v=527.
- Address 50 fetched at h=974, v=0.

REQ-019 Pixel mapping: set word 0 = 16'h0001 and word 49 = 16'h8000, all other words 0.
- On line 0, pixel = 1 only at x=0 and x=799.
- Each transition appears 1 cycle after the matching h.

REQ-020 Box image: load a 101x101 black box at x,y 150..250 into an otherwise all-ones buffer.
- pixel = 0 exactly inside the box on visible cycles.
- pixel = 1 elsewhere on visible cycles.
- pixel = 0 whenever de = 0.

REQ-021 Mid-frame reset: assert reset at v=200, h=500 for 3 cycles, then release.
- During reset: hsync = 1, vsync = 1, de = 0, rd_en = 0, rd_addr = 0.
- After release, counters restart at 0 and the next prefetch uses address 0.

REQ-022 Latency: check that rd_data is sampled exactly 1 cycle after rd_en.
- Corrupt rd_data on all other cycles.
- The displayed image SHALL be unchanged.
